pipe_stage_reg: RTL

Parametrised pipeline stage register carrying a WIDTH-bit control/data bundle between two pipeline stages, for example decode to execute. It generalises the fixed-field stage registers with a valid/ready handshake and a flush that inserts a configurable NOP bundle. It also provides an optional one-entry skid buffer that breaks the combinational ready path, and a saturating bubble counter for performance monitoring. One instance per stage boundary.

---
 rtl/pipe_pkg.sv | 57 +++++
 rtl/pipe_skid_buf.sv | 63 ++++++
 rtl/pipe_stage_reg.sv | 100 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared stage-boundary definitions: bundle widths, canonical NOP bundles
// and field offsets used to pack/unpack stage bundles.
package pipe_pkg;

    localparam int IF_ID_W  = 64;
    localparam int DE_W     = 14;
    localparam int EX_MEM_W = 72;

    localparam int DE_BR_LSB    = 0;
    localparam int DE_BR_W      = 3;
    localparam int DE_WB_LSB    = 3;
    localparam int DE_WB_W      = 2;
    localparam int DE_RD_BIT    = 5;
    localparam int DE_WR_BIT    = 6;
    localparam int DE_SELB_BIT  = 7;
    localparam int DE_SELA_BIT  = 8;
    localparam int DE_REGWR_BIT = 9;
    localparam int DE_ALU_LSB   = 10;
    localparam int DE_ALU_W     = 4;

    typedef struct packed {
        logic [DE_ALU_W-1:0] alu_op;
        logic                reg_wr;
        logic                sel_A;
        logic                sel_B;
        logic                wr_en;
        logic                rd_en;
        logic [DE_WB_W-1:0]  wb_sel;
        logic [DE_BR_W-1:0]  br_type;
    } de_bundle_t;

    localparam de_bundle_t DE_NOP_S = '{
        alu_op:  4'd0,
        reg_wr:  1'b0,
        sel_A:   1'b1,
        sel_B:   1'b0,
        wr_en:   1'b0,
        rd_en:   1'b0,
        wb_sel:  2'd1,
        br_type: 3'd2
    };

    localparam logic [DE_W-1:0] DE_NOP = DE_NOP_S;

    // addi x0,x0,0 in the instruction half, zero PC
    localparam logic [IF_ID_W-1:0] IF_ID_NOP = {32'h0000_0013, 32'h0};
    localparam logic [EX_MEM_W-1:0] EX_MEM_NOP = '0;

    function automatic logic [DE_W-1:0] de_pack(input de_bundle_t b);
        return b;
    endfunction

    function automatic de_bundle_t de_unpack(input logic [DE_W-1:0] v);
        return de_bundle_t'(v);
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid buffer with registered in_ready; only built when
// PIPE_SKID_EN is defined.
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_xfer_in,
    input  logic             i_main_full,
    input  logic             i_xfer_out,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_in_ready
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_in_ready;
    logic             w_load;
    logic             w_drain;
    logic             w_valid_nxt;

    // Capture only when the main register is held by a stalled consumer
    assign w_load  = i_xfer_in && i_main_full && !i_xfer_out;
    assign w_drain = r_valid && i_xfer_out;

    always_comb begin
        w_valid_nxt = r_valid;
        if (i_flush) begin
            w_valid_nxt = 1'b0;
        end else if (w_drain) begin
            w_valid_nxt = 1'b0;
        end else if (w_load) begin
            w_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_data     <= NOP_VALUE;
            r_in_ready <= 1'b1;
        end else begin
            r_valid    <= w_valid_nxt;
            r_in_ready <= !w_valid_nxt;
            if (i_flush || w_drain) begin
                r_data <= NOP_VALUE;
            end else if (w_load) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid    = r_valid;
    assign o_data     = r_data;
    assign o_in_ready = r_in_ready;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush-to-NOP and bubble counter.
// Define PIPE_SKID_EN for a one-entry skid buffer and registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_VALUE = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] bubble_cnt
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_bubble;
    logic             w_xfer_in;
    logic             w_xfer_out;
    logic             w_skid_valid;
    logic [WIDTH-1:0] w_skid_data;
    logic             w_valid_nxt;
    logic [WIDTH-1:0] w_data_nxt;

    assign w_xfer_in  = in_valid && in_ready && !flush;
    assign w_xfer_out = r_valid && out_ready;

`ifdef PIPE_SKID_EN
    pipe_skid_buf #(
        .WIDTH     (WIDTH),
        .NOP_VALUE (NOP_VALUE)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (flush),
        .i_xfer_in   (w_xfer_in),
        .i_main_full (r_valid),
        .i_xfer_out  (w_xfer_out),
        .i_data      (in_data),
        .o_valid     (w_skid_valid),
        .o_data      (w_skid_data),
        .o_in_ready  (in_ready)
    );
`else
    assign w_skid_valid = 1'b0;
    assign w_skid_data  = NOP_VALUE;
    assign in_ready     = out_ready || !r_valid;
`endif

    // A held skid entry is older than anything upstream, so it refills first
    always_comb begin
        w_valid_nxt = r_valid;
        w_data_nxt  = r_data;
        if (flush) begin
            w_valid_nxt = 1'b0;
            w_data_nxt  = NOP_VALUE;
        end else if (w_skid_valid) begin
            if (w_xfer_out) begin
                w_valid_nxt = 1'b1;
                w_data_nxt  = w_skid_data;
            end
        end else if (w_xfer_in && (!r_valid || w_xfer_out)) begin
            w_valid_nxt = 1'b1;
            w_data_nxt  = in_data;
        end else if (w_xfer_out) begin
            w_valid_nxt = 1'b0;
            w_data_nxt  = NOP_VALUE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= NOP_VALUE;
        end else begin
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bubble <= '0;
        end else if (!r_valid && (r_bubble != '1)) begin
            r_bubble <= r_bubble + CNT_W'(1);
        end
    end

    assign out_valid  = r_valid;
    assign out_data   = r_data;
    assign bubble_cnt = r_bubble;

endmodule
